agc_io_host_bridge: RTL

Responder on the core's 3-bit-select IO channel port, bridging AGC IO channels to an external byte-stream host link. It queues core channel writes in a FIFO and encodes each as a 3-byte frame on a valid/ready TX stream. It decodes 3-byte frames from an RX stream into seven input channel registers, which the core reads combinationally. Channel 7 is a local status/control register.

---
 rtl/agc_io_bridge_pkg.sv | 43 ++++
 rtl/io_fifo.sv | 67 ++++++
 rtl/agc_io_host_bridge.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/agc_io_bridge_pkg.sv
// +--------------------------------------------------------------------+
// | agc_io_bridge_pkg : shared types, constants and frame byte builder |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package agc_io_bridge_pkg;

   typedef enum logic [1:0] {
      ENC_IDLE = 2'd0,
      ENC_B0   = 2'd1,
      ENC_B1   = 2'd2,
      ENC_B2   = 2'd3
   } enc_state_t;

   typedef enum logic [1:0] {
      DEC_WAIT_HDR = 2'd0,
      DEC_GOT_HDR  = 2'd1,
      DEC_GOT_HI   = 2'd2
   } dec_state_t;

   localparam logic [2:0] CHAN_STATUS = 3'd7;
   localparam int         OVF_BIT     = 14;
   localparam int         FERR_BIT    = 13;
   localparam logic       HDR_MARK    = 1'b1;
   localparam int         ENTRY_W     = 18;

   // Only the header byte carries the MSB mark, so payload bytes are 7 bits wide.
   function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                             input logic [2:0]  sel,
                                             input logic [14:0] data);
      logic [7:0] b;
      case (idx)
         2'd0:    b = {HDR_MARK, 3'b000, data[14], sel};
         2'd1:    b = {~HDR_MARK, data[13:7]};
         default: b = {~HDR_MARK, data[6:0]};
      endcase
      return b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/io_fifo.sv
// +--------------------------------------------------------------------+
// | io_fifo : synchronous FIFO with push/pop/full/empty/count          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module io_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 18,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A simultaneous pop frees the slot, so a full FIFO may still accept.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/agc_io_host_bridge.sv
// +--------------------------------------------------------------------+
// | agc_io_host_bridge : AGC IO channels <-> 3-byte-frame host link    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module agc_io_host_bridge
   import agc_io_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        IO_write_en,
   input  logic [2:0]  IO_write_sel,
   input  logic [14:0] IO_write_data,
   input  logic [2:0]  IO_read_sel,
   output logic [14:0] IO_read_data,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        io_overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic               wr_queue, wr_status;
   logic               fifo_pop, fifo_full, fifo_empty;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic [CW-1:0]      fifo_count;
   logic [4:0]         cnt5;

   enc_state_t         enc_state_q, enc_state_d;
   logic [ENTRY_W-1:0] hold_q, hold_d;
   logic               tx_accept;

   dec_state_t         dec_state_q, dec_state_d;
   logic [2:0]         dsel_q, dsel_d;
   logic               d14_q, d14_d;
   logic [6:0]         hi7_q, hi7_d;
   logic [6:0][14:0]   in_chan_q, in_chan_d;
   logic               rx_ready_q, rx_accept, ferr_set;

   logic               ovf_q, ovf_d, ferr_q, ferr_d;

   assign wr_queue  = IO_write_en && (IO_write_sel != CHAN_STATUS);
   assign wr_status = IO_write_en && (IO_write_sel == CHAN_STATUS);

   io_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (wr_queue),
      .pop     (fifo_pop),
      .wdata   ({IO_write_sel, IO_write_data}),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      enc_state_d = enc_state_q;
      hold_d      = hold_q;
      fifo_pop    = 1'b0;
      tx_byte     = 8'h00;
      tx_valid    = (enc_state_q != ENC_IDLE);
      tx_accept   = tx_valid && tx_ready;
      case (enc_state_q)
         ENC_IDLE: if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            hold_d      = fifo_rdata;
            enc_state_d = ENC_B0;
         end
         ENC_B0: begin
            tx_byte = frame_byte(2'd0, hold_q[17:15], hold_q[14:0]);
            if (tx_accept) enc_state_d = ENC_B1;
         end
         ENC_B1: begin
            tx_byte = frame_byte(2'd1, hold_q[17:15], hold_q[14:0]);
            if (tx_accept) enc_state_d = ENC_B2;
         end
         default: begin
            tx_byte = frame_byte(2'd2, hold_q[17:15], hold_q[14:0]);
            if (tx_accept) begin
               if (!fifo_empty) begin
                  fifo_pop    = 1'b1;
                  hold_d      = fifo_rdata;
                  enc_state_d = ENC_B0;
               end else begin
                  enc_state_d = ENC_IDLE;
               end
            end
         end
      endcase
   end

   // Any header byte restarts the frame; one arriving mid-frame is a resync.
   always_comb begin
      dec_state_d = dec_state_q;
      dsel_d      = dsel_q;
      d14_d       = d14_q;
      hi7_d       = hi7_q;
      in_chan_d   = in_chan_q;
      ferr_set    = 1'b0;
      rx_accept   = rx_valid && rx_ready_q;
      if (rx_accept) begin
         if (rx_byte[7] == HDR_MARK) begin
            dsel_d      = rx_byte[2:0];
            d14_d       = rx_byte[3];
            ferr_set    = (dec_state_q != DEC_WAIT_HDR);
            dec_state_d = DEC_GOT_HDR;
         end else begin
            case (dec_state_q)
               DEC_GOT_HDR: begin
                  hi7_d       = rx_byte[6:0];
                  dec_state_d = DEC_GOT_HI;
               end
               DEC_GOT_HI: begin
                  for (int i = 0; i < 7; i++)
                     if (dsel_q == 3'(i)) in_chan_d[i] = {d14_q, hi7_q, rx_byte[6:0]};
                  dec_state_d = DEC_WAIT_HDR;
               end
               default: begin
                  ferr_set    = 1'b1;
                  dec_state_d = DEC_WAIT_HDR;
               end
            endcase
         end
      end
   end

   always_comb begin
      ovf_d  = (wr_queue && fifo_full && !fifo_pop)
             | (ovf_q && !(wr_status && IO_write_data[0]));
      ferr_d = ferr_set | (ferr_q && !(wr_status && IO_write_data[1]));
   end

   always_comb begin
      cnt5           = '0;
      cnt5[CW-1:0]   = fifo_count;
      IO_read_data   = '0;
      for (int i = 0; i < 7; i++)
         if (IO_read_sel == 3'(i)) IO_read_data = in_chan_q[i];
      if (IO_read_sel == CHAN_STATUS) begin
         IO_read_data           = {10'b0, cnt5};
         IO_read_data[OVF_BIT]  = ovf_q;
         IO_read_data[FERR_BIT] = ferr_q;
      end
   end

   assign rx_ready    = rx_ready_q;
   assign io_overflow = ovf_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         enc_state_q <= ENC_IDLE;
         hold_q      <= '0;
         dec_state_q <= DEC_WAIT_HDR;
         dsel_q      <= '0;
         d14_q       <= 1'b0;
         hi7_q       <= '0;
         in_chan_q   <= '0;
         rx_ready_q  <= 1'b0;
         ovf_q       <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         enc_state_q <= enc_state_d;
         hold_q      <= hold_d;
         dec_state_q <= dec_state_d;
         dsel_q      <= dsel_d;
         d14_q       <= d14_d;
         hi7_q       <= hi7_d;
         in_chan_q   <= in_chan_d;
         rx_ready_q  <= 1'b1;
         ovf_q       <= ovf_d;
         ferr_q      <= ferr_d;
      end
   end

endmodule

`default_nettype wire
